mips_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-cycle MIPS datapath (instruction slicer, register file, ALU, data memory). It accepts one instruction word at a time over a newinstr/ready handshake and latches it. It then steps the datapath through DECODE, EXEC, MEM and WB, issuing one-cycle strobes so that register-file writes and memory accesses happen exactly once per instruction. It also owns the program counter, reports completion, and flags unsupported opcodes.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mips_opdecode.sv | 46 ++++
 rtl/mips_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_mips_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALUOp codes, sequencer states and control bundle
//
// Purpose: common definitions for the MIPS control path. Imported by
// mips_opdecode and mips_sequencer.
// Ports: none (package).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       is_ld;
    logic       is_st;
    logic       is_br;
    logic       legal;
  } ctrl_t;

endpackage

// File: rtl/mips_opdecode.sv
// rtl/mips_opdecode.sv - combinational opcode to control-bundle decoder
//
// Purpose: maps a 6-bit primary opcode to the datapath control bundle.
// Holds no state so a pipelined core can reuse it in its decode stage.
// Ports:
//   i_opcode  in  6       instruction bits [31:26]
//   o_ctrl    out ctrl_t  mux selects, ALUOp, class flags and legal bit
module mips_opdecode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  // Unlisted opcodes fall through with legal=0 and every select low.
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.regdst = 1'b1;
        o_ctrl.aluop  = ALUOP_FUNCT;
        o_ctrl.legal  = 1'b1;
      end
      OP_LW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.aluop    = ALUOP_ADD;
        o_ctrl.is_ld    = 1'b1;
        o_ctrl.legal    = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alusrc = 1'b1;
        o_ctrl.aluop  = ALUOP_ADD;
        o_ctrl.is_st  = 1'b1;
        o_ctrl.legal  = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.aluop = ALUOP_SUB;
        o_ctrl.is_br = 1'b1;
        o_ctrl.legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_sequencer.sv
// rtl/mips_sequencer.sv - multi-cycle control sequencer for the MIPS datapath
//
// Purpose: accepts one instruction over newinstr/ready, latches it in ir,
// and steps the datapath through DECODE, EXEC, MEM and WB with one-shot
// strobes. Owns the program counter and reports done / illegal.
// Ports:
//   clock      in  1   rising-edge clock
//   reset      in  1   asynchronous active-low reset
//   newinstr   in  1   request valid, sampled while ready=1
//   instrword  in  32  instruction captured into ir on acceptance
//   alu_zero   in  1   ALU zero flag, sampled in EXEC for beq
//   ready      out 1   idle and able to accept
//   ir         out 32  latched instruction
//   reg_rd_en  out 1   register read strobe (DECODE)
//   alu_en     out 1   ALU evaluate strobe (EXEC)
//   mem_rd     out 1   data-memory read strobe (MEM, lw)
//   mem_wr     out 1   data-memory write strobe (MEM, sw)
//   reg_wr     out 1   register write strobe (WB)
//   regdst, alusrc, memtoreg  out 1  datapath mux selects
//   aluop      out 2   00 add, 01 sub, 10 funct
//   pc         out 32  program counter
//   done       out 1   one-cycle completion pulse
//   illegal    out 1   one-cycle unsupported-opcode pulse
module mips_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        newinstr,
  input  logic [31:0] instrword,
  input  logic        alu_zero,
  output logic        ready,
  output logic [31:0] ir,
  output logic        reg_rd_en,
  output logic        alu_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic        regdst,
  output logic        alusrc,
  output logic        memtoreg,
  output logic [1:0]  aluop,
  output logic [31:0] pc,
  output logic        done,
  output logic        illegal
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT);

  state_t      r_state;
  state_t      w_next;
  logic        r_live;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [3:0]  r_cnt;
  ctrl_t       r_ctrl;
  logic        r_done;
  logic        r_illegal;

  ctrl_t       w_dec;
  logic        w_accept;
  logic        w_load_ctrl;
  logic        w_load_cnt;
  logic        w_cnt_dec;
  logic        w_complete;
  logic        w_take;
  logic        w_illegal;
  logic [31:0] w_pc_seq;
  logic [31:0] w_br_off;

  mips_opdecode u_opdecode (
    .i_opcode (r_ir[31:26]),
    .o_ctrl   (w_dec)
  );

  // r_live keeps ready low while reset is held and for the release edge,
  // so ready never depends combinationally on the reset pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_load_ctrl = 1'b0;
    w_load_cnt  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_complete  = 1'b0;
    w_take      = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_live && newinstr) begin
          w_accept = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_dec.legal) begin
          w_load_ctrl = 1'b1;
          w_next      = S_EXEC;
        end else begin
          w_illegal = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_ctrl.is_br) begin
          w_complete = 1'b1;
          w_take     = alu_zero;
          w_next     = S_IDLE;
        end else if (r_ctrl.is_ld || r_ctrl.is_st) begin
          w_load_cnt = 1'b1;
          w_next     = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        // Counter holds cycles remaining including this one.
        if (r_cnt <= 4'd1) begin
          if (r_ctrl.is_ld) begin
            w_next = S_WB;
          end else begin
            w_complete = 1'b1;
            w_next     = S_IDLE;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_WB: begin
        w_complete = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_pc_seq = r_pc + 32'd4;
  assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ir      <= '0;
      r_pc      <= RESET_PC;
      r_cnt     <= '0;
      r_ctrl    <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= w_complete;
      r_illegal <= w_illegal;
      if (w_accept) begin
        r_ir <= instrword;
      end
      if (w_load_ctrl) begin
        r_ctrl <= w_dec;
      end
      if (w_load_cnt) begin
        r_cnt <= CNT_INIT;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_complete) begin
        r_pc <= w_take ? (w_pc_seq + w_br_off) : w_pc_seq;
      end
    end
  end

  // Strobes are pure state decodes, so at most one is high per cycle.
  // An illegal opcode issues no register read.
  assign ready     = r_live && (r_state == S_IDLE);
  assign reg_rd_en = (r_state == S_DECODE) && w_dec.legal;
  assign alu_en    = (r_state == S_EXEC);
  assign mem_rd    = (r_state == S_MEM) && r_ctrl.is_ld;
  assign mem_wr    = (r_state == S_MEM) && r_ctrl.is_st;
  assign reg_wr    = (r_state == S_WB);

  assign ir       = r_ir;
  assign pc       = r_pc;
  assign regdst   = r_ctrl.regdst;
  assign alusrc   = r_ctrl.alusrc;
  assign memtoreg = r_ctrl.memtoreg;
  assign aluop    = r_ctrl.aluop;
  assign done     = r_done;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_mips_sequencer.sv
// tb/tb_mips_sequencer.sv - directed self-checking bench for mips_sequencer
module tb_mips_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] instrword = 32'h0;

  logic        newinstr_v  [3];
  logic        ready_v     [3];
  logic [31:0] ir_v        [3];
  logic        reg_rd_en_v [3];
  logic        alu_en_v    [3];
  logic        mem_rd_v    [3];
  logic        mem_wr_v    [3];
  logic        reg_wr_v    [3];
  logic        regdst_v    [3];
  logic        alusrc_v    [3];
  logic        memtoreg_v  [3];
  logic [1:0]  aluop_v     [3];
  logic [31:0] pc_v        [3];
  logic        done_v      [3];
  logic        illegal_v   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Instance g runs with MEM_WAIT=g+1; instance 2 starts from pc 0x80.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_sequencer #(
      .MEM_WAIT (g + 1),
      .RESET_PC ((g == 2) ? 32'h0000_0080 : 32'h0000_0000)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .newinstr  (newinstr_v[g]),
      .instrword (instrword),
      .alu_zero  (alu_zero),
      .ready     (ready_v[g]),
      .ir        (ir_v[g]),
      .reg_rd_en (reg_rd_en_v[g]),
      .alu_en    (alu_en_v[g]),
      .mem_rd    (mem_rd_v[g]),
      .mem_wr    (mem_wr_v[g]),
      .reg_wr    (reg_wr_v[g]),
      .regdst    (regdst_v[g]),
      .alusrc    (alusrc_v[g]),
      .memtoreg  (memtoreg_v[g]),
      .aluop     (aluop_v[g]),
      .pc        (pc_v[g]),
      .done      (done_v[g]),
      .illegal   (illegal_v[g])
    );
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic [31:0] w);
    instrword     = w;
    newinstr_v[k] = 1'b1;
    tick();
    newinstr_v[k] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) newinstr_v[i] = 1'b0;

    // Reset state
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_ready", ready_v[1], 32'd0);
    chk("rst_pc1", pc_v[1], 32'h0);
    chk("rst_pc2", pc_v[2], 32'h80);
    chk("rst_ir", ir_v[1], 32'h0);
    chk("rst_done", done_v[1], 32'd0);
    chk("rst_aluop", aluop_v[1], 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_ready", ready_v[1], 32'd1);

    // R-type add on instance 1
    issue(1, 32'h012A4020);
    chk("r_dec_rd", reg_rd_en_v[1], 32'd1);
    chk("r_dec_ready", ready_v[1], 32'd0);
    chk("r_dec_alu", alu_en_v[1], 32'd0);
    tick();
    chk("r_ex_alu", alu_en_v[1], 32'd1);
    chk("r_ex_rd", reg_rd_en_v[1], 32'd0);
    chk("r_regdst", regdst_v[1], 32'd1);
    chk("r_aluop", aluop_v[1], 32'd2);
    chk("r_alusrc", alusrc_v[1], 32'd0);
    tick();
    chk("r_wb", reg_wr_v[1], 32'd1);
    chk("r_wb_alu", alu_en_v[1], 32'd0);
    tick();
    chk("r_done", done_v[1], 32'd1);
    chk("r_pc", pc_v[1], 32'h4);
    chk("r_ready", ready_v[1], 32'd1);
    chk("r_ir", ir_v[1], 32'h012A4020);
    chk("r_wb_off", reg_wr_v[1], 32'd0);
    tick();
    chk("r_done_pulse", done_v[1], 32'd0);

    // lw with MEM_WAIT=2
    issue(1, 32'h8C080000);
    tick();
    chk("lw_ex_alu", alu_en_v[1], 32'd1);
    chk("lw_memtoreg", memtoreg_v[1], 32'd1);
    chk("lw_alusrc", alusrc_v[1], 32'd1);
    chk("lw_regdst", regdst_v[1], 32'd0);
    chk("lw_aluop", aluop_v[1], 32'd0);
    chk("lw_ex_memrd", mem_rd_v[1], 32'd0);
    tick();
    chk("lw_mem1", mem_rd_v[1], 32'd1);
    chk("lw_mem1_wr", mem_wr_v[1], 32'd0);
    tick();
    chk("lw_mem2", mem_rd_v[1], 32'd1);
    chk("lw_mem2_regwr", reg_wr_v[1], 32'd0);
    tick();
    chk("lw_wb_memrd", mem_rd_v[1], 32'd0);
    chk("lw_wb", reg_wr_v[1], 32'd1);
    chk("lw_wb_done", done_v[1], 32'd0);
    tick();
    chk("lw_done", done_v[1], 32'd1);
    chk("lw_pc", pc_v[1], 32'h8);
    chk("lw_regwr_off", reg_wr_v[1], 32'd0);

    // beq taken at pc=8, offset -1 word
    alu_zero = 1'b1;
    issue(1, 32'h1109FFFF);
    tick();
    chk("beq_alu", alu_en_v[1], 32'd1);
    chk("beq_aluop", aluop_v[1], 32'd1);
    chk("beq_alusrc", alusrc_v[1], 32'd0);
    tick();
    chk("beq_t_done", done_v[1], 32'd1);
    chk("beq_t_pc", pc_v[1], 32'h8);
    chk("beq_t_regwr", reg_wr_v[1], 32'd0);

    // beq not taken
    alu_zero = 1'b0;
    issue(1, 32'h1109FFFF);
    tick();
    tick();
    chk("beq_n_done", done_v[1], 32'd1);
    chk("beq_n_pc", pc_v[1], 32'hC);

    // Illegal opcode 2
    issue(1, 32'h08000000);
    chk("ill_dec_illegal", illegal_v[1], 32'd0);
    tick();
    chk("ill_pulse", illegal_v[1], 32'd1);
    chk("ill_done", done_v[1], 32'd0);
    chk("ill_pc", pc_v[1], 32'hC);
    chk("ill_ready", ready_v[1], 32'd1);
    chk("ill_alu", alu_en_v[1], 32'd0);
    tick();
    chk("ill_pulse_end", illegal_v[1], 32'd0);
    chk("ill_pc_hold", pc_v[1], 32'hC);

    // Three back-to-back R-types on instance 0, request held high
    instrword     = 32'h012A4020;
    newinstr_v[0] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      tick();
      chk("b2b_done", done_v[0], 32'd1);
      chk("b2b_ready", ready_v[0], 32'd1);
      chk("b2b_pc", pc_v[0], 32'(4 * (i + 1)));
      if (i == 2) newinstr_v[0] = 1'b0;
      tick();
      chk("b2b_next_rd", reg_rd_en_v[0], (i == 2) ? 32'd0 : 32'd1);
    end
    chk("b2b_idle_ready", ready_v[0], 32'd1);
    chk("b2b_pc_final", pc_v[0], 32'hC);

    // sw with MEM_WAIT=1 on instance 0
    issue(0, 32'hAC080004);
    tick();
    chk("sw_alusrc", alusrc_v[0], 32'd1);
    chk("sw_regdst", regdst_v[0], 32'd0);
    chk("sw_memtoreg", memtoreg_v[0], 32'd0);
    chk("sw_aluop", aluop_v[0], 32'd0);
    tick();
    chk("sw_mem_wr", mem_wr_v[0], 32'd1);
    chk("sw_mem_rd", mem_rd_v[0], 32'd0);
    chk("sw_mem_regwr", reg_wr_v[0], 32'd0);
    tick();
    chk("sw_done", done_v[0], 32'd1);
    chk("sw_wr_off", mem_wr_v[0], 32'd0);
    chk("sw_regwr", reg_wr_v[0], 32'd0);
    chk("sw_pc", pc_v[0], 32'h10);

    // Reset mid-MEM on instance 2 (MEM_WAIT=3, RESET_PC=0x80)
    issue(2, 32'h012A4020);
    tick();
    tick();
    tick();
    chk("rm_r_pc", pc_v[2], 32'h84);
    issue(2, 32'h8C080000);
    tick();
    tick();
    chk("rm_mem1", mem_rd_v[2], 32'd1);
    tick();
    chk("rm_mem2", mem_rd_v[2], 32'd1);
    reset = 1'b0;
    #1;
    chk("rm_memrd", mem_rd_v[2], 32'd0);
    chk("rm_pc", pc_v[2], 32'h80);
    chk("rm_ready", ready_v[2], 32'd0);
    chk("rm_ir", ir_v[2], 32'h0);
    chk("rm_memtoreg", memtoreg_v[2], 32'd0);
    tick();
    chk("rm_hold_memrd", mem_rd_v[2], 32'd0);
    chk("rm_hold_regwr", reg_wr_v[2], 32'd0);
    reset = 1'b1;
    tick();
    chk("rm_rel_ready", ready_v[2], 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rm_no_regwr", reg_wr_v[2], 32'd0);
      chk("rm_no_memrd", mem_rd_v[2], 32'd0);
    end
    chk("rm_pc_final", pc_v[2], 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
